// File: rtl/config_pkg.sv
// Shared types and constants for the tile configuration loader.
package config_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ADDR,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_t;

    // Address field layout: tile_id in the upper half, config_id in the lower half.
    localparam int TILE_ID_MSB   = 31;
    localparam int TILE_ID_LSB   = 16;
    localparam int CONFIG_ID_MSB = 15;
    localparam int CONFIG_ID_LSB = 0;

    // No tile answers to this tile_id, so parking the bus on it is harmless.
    localparam logic [15:0] IDLE_TILE_ID  = 16'hFFFF;
    localparam logic [15:0] DEFAULT_MAGIC = 16'hC0F1;

endpackage

// File: rtl/config_loader_if.sv
// Byte stream in, broadcast configuration bus out.
// master = the loader (stream sink, config bus driver); slave = its environment.
interface config_loader_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        config_we;

    modport master (
        input  in_byte, in_valid,
        output in_ready, config_addr, config_data, config_we
    );

    modport slave (
        output in_byte, in_valid,
        input  in_ready, config_addr, config_data, config_we
    );
endinterface

// File: rtl/config_loader_assembler.sv
// Collects four accepted bytes into a little-endian 32-bit word.
// word is combinational so the caller can use the completed value in the
// same cycle the fourth byte is accepted (word_done high).
module byte_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_done
);
    logic [1:0]  idx;
    logic [23:0] sr;

    // Byte index and shift register; earlier bytes drift toward bit 0.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx <= 2'd0;
            sr  <= 24'd0;
        end else if (en) begin
            idx <= idx + 2'd1;
            sr  <= {in_byte, sr[23:8]};
        end
    end

    assign word      = {in_byte, sr};
    assign word_done = en && (idx == 2'd3);

endmodule

// File: rtl/config_loader.sv
// Configuration master: parses header + address/data records from a byte
// stream and issues one config_we strobe per record on the broadcast bus.
module config_loader
    import config_pkg::*;
#(
    parameter logic [15:0] MAGIC     = DEFAULT_MAGIC,
    parameter logic [31:0] IDLE_ADDR = {IDLE_TILE_ID, 16'hFFFF}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    config_loader_if.master   bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       writes_done
);
    state_t      state;
    logic        in_ready_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        we_q;
    logic [31:0] addr_shadow;
    logic [15:0] remaining;

    logic        accept;
    logic        can_start;
    logic [31:0] word;
    logic        word_done;

    assign accept    = bus.in_valid && in_ready_q;
    assign can_start = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);

    assign bus.in_ready    = in_ready_q;
    assign bus.config_addr = addr_q;
    assign bus.config_data = data_q;
    assign bus.config_we   = we_q;

    byte_word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (can_start),
        .en        (accept),
        .in_byte   (bus.in_byte),
        .word      (word),
        .word_done (word_done)
    );

    // Load sequencer; every output is registered and set on the transition
    // into the state that owns it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            in_ready_q  <= 1'b0;
            addr_q      <= IDLE_ADDR;
            data_q      <= 32'd0;
            we_q        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            writes_done <= 16'd0;
            addr_shadow <= 32'd0;
            remaining   <= 16'd0;
        end else begin
            we_q <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state       <= ST_HDR;
                        in_ready_q  <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        writes_done <= 16'd0;
                    end
                end
                ST_HDR: begin
                    // Header word: magic in [15:0], record count in [31:16].
                    if (word_done) begin
                        if (word[15:0] != MAGIC) begin
                            state      <= ST_ERR;
                            in_ready_q <= 1'b0;
                            busy       <= 1'b0;
                            error      <= 1'b1;
                        end else if (word[31:16] == 16'd0) begin
                            state      <= ST_DONE;
                            in_ready_q <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end else begin
                            state     <= ST_ADDR;
                            remaining <= word[31:16];
                        end
                    end
                end
                ST_ADDR: begin
                    if (word_done) begin
                        state       <= ST_DATA;
                        addr_shadow <= word;
                    end
                end
                ST_DATA: begin
                    // Present the record on the bus for exactly the WRITE cycle.
                    if (word_done) begin
                        state      <= ST_WRITE;
                        in_ready_q <= 1'b0;
                        we_q       <= 1'b1;
                        addr_q     <= addr_shadow;
                        data_q     <= word;
                    end
                end
                ST_WRITE: begin
                    addr_q      <= IDLE_ADDR;
                    writes_done <= writes_done + 16'd1;
                    remaining   <= remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state      <= ST_ADDR;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench for config_loader: stimulus builds the byte stream from
// header/record values and queues expected writes; a monitor checks each strobe.
module tb_config_loader;
    import config_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done, error;
    logic [15:0] writes_done;

    config_loader_if bus ();

    config_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .writes_done (writes_done)
    );

    always #5 clk = ~clk;

    int          total  = 0;
    int          passed = 0;
    logic [63:0] exp_q[$];   // {addr, data} per expected write
    logic [63:0] recs[$];    // records for the next load

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest expected record.
    always @(negedge clk) begin : mon
        logic [63:0] e;
        if (!reset && bus.config_we) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_we: got addr %h data %h expected no write",
                         bus.config_addr, bus.config_data);
            end else begin
                e = exp_q.pop_front();
                chk("we_addr", bus.config_addr, e[63:32]);
                chk("we_data", bus.config_data, e[31:0]);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte (after optional idle cycles) and hold until accepted.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc;
        repeat (gap) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        for (int n = 0; ; n++) begin
            acc = bus.in_ready;
            @(negedge clk);
            if (acc) break;
            if (n > 100) begin
                total++;
                $display("FAIL byte_timeout: got in_ready 0 for %0d cycles expected accept", n);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // mode: 0 back-to-back, 1 valid every other cycle, 2 random gaps.
    // limit >= 0 sends only that many bytes and queues no writes (aborted load).
    task automatic load(input logic [15:0] magic, input logic [15:0] count,
                        input int mode, input int limit, input bit poke_start);
        logic [7:0]  q[$];
        logic [31:0] h, a, d;
        int          n, gap;
        h = {count, magic};
        for (int i = 0; i < 4; i++) q.push_back(h[8*i +: 8]);
        if (magic == DEFAULT_MAGIC) begin
            for (int r = 0; r < recs.size(); r++) begin
                a = recs[r][63:32];
                d = recs[r][31:0];
                for (int i = 0; i < 4; i++) q.push_back(a[8*i +: 8]);
                for (int i = 0; i < 4; i++) q.push_back(d[8*i +: 8]);
                if (limit < 0) exp_q.push_back(recs[r]);
            end
        end
        n = (limit < 0) ? q.size() : limit;
        for (int i = 0; i < n; i++) begin
            if (poke_start && i == 6) pulse_start();  // busy: must be ignored
            gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 3));
            send_byte(q[i], gap);
            // Back-to-back: we're now in the WRITE cycle; the next byte is
            // offered immediately and must wait one cycle.
            if (mode == 0 && i >= 11 && ((i - 4) % 8) == 7) begin
                chk("write_we", {31'd0, bus.config_we}, 32'd1);
                chk("write_in_ready", {31'd0, bus.in_ready}, 32'd0);
            end
        end
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100 && busy; n++) @(negedge clk);
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        chk({tag, "_addr"}, bus.config_addr, 32'hFFFF_FFFF);
        chk({tag, "_data"}, bus.config_data, 32'd0);
        chk({tag, "_we"}, {31'd0, bus.config_we}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_writes"}, {16'd0, writes_done}, 32'd0);
    endtask

    task automatic random_recs(input int cnt);
        recs.delete();
        for (int r = 0; r < cnt; r++) recs.push_back({$urandom(), $urandom()});
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'd0;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);

        // 1: single directed record
        recs.delete();
        recs.push_back({32'h0001_0004, 32'hDEAD_BEEF});
        pulse_start();
        load(DEFAULT_MAGIC, 16'd1, 0, -1, 1'b0);
        wait_idle();
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_writes", {16'd0, writes_done}, 32'd1);
        chk("t1_addr_idle", bus.config_addr, 32'hFFFF_FFFF);

        // 2: byte-swapped magic -> ERR, then restart
        recs.delete();
        pulse_start();
        load(16'hF1C0, 16'd1, 0, -1, 1'b0);
        wait_idle();
        chk("t2_error", {31'd0, error}, 32'd1);
        chk("t2_done", {31'd0, done}, 32'd0);
        chk("t2_in_ready", {31'd0, bus.in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        pulse_start();
        chk("t2_busy", {31'd0, busy}, 32'd1);
        chk("t2_error_clr", {31'd0, error}, 32'd0);
        chk("t2_in_ready_hdr", {31'd0, bus.in_ready}, 32'd1);
        random_recs(2);
        load(DEFAULT_MAGIC, 16'd2, 2, -1, 1'b0);
        wait_idle();
        chk("t2_writes", {16'd0, writes_done}, 32'd2);

        // 3: three records, valid toggling
        random_recs(3);
        pulse_start();
        load(DEFAULT_MAGIC, 16'd3, 1, -1, 1'b0);
        wait_idle();
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_writes", {16'd0, writes_done}, 32'd3);

        // 4: empty load
        recs.delete();
        pulse_start();
        load(DEFAULT_MAGIC, 16'd0, 0, -1, 1'b0);
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_writes", {16'd0, writes_done}, 32'd0);

        // 5: reset after six record bytes
        random_recs(1);
        pulse_start();
        load(DEFAULT_MAGIC, 16'd1, 0, 10, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_values("t5");
        @(negedge clk);

        // 6: back-to-back records, next byte held through WRITE
        random_recs(2);
        pulse_start();
        load(DEFAULT_MAGIC, 16'd2, 0, -1, 1'b0);
        wait_idle();
        chk("t6_writes", {16'd0, writes_done}, 32'd2);

        // 7: random loads, one with a start pulse while busy
        for (int k = 0; k < 6; k++) begin
            int cnt;
            cnt = int'($urandom_range(1, 4));
            random_recs(cnt);
            pulse_start();
            load(DEFAULT_MAGIC, 16'(cnt), 2, -1, k == 0);
            wait_idle();
            chk("t7_done", {31'd0, done}, 32'd1);
            chk("t7_writes", {16'd0, writes_done}, cnt);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
